// File: rtl/fmc_i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// fmc_i2c_init_sequencer
//
// Walks a small table of I2C register writes (FMC424 CPLD select, SI5338B
// setup) and turns each entry into three byte commands for the FMC I2C byte
// engine: START+WRITE(dev addr), WRITE(reg), WRITE+STOP(data). A NACK is
// retried with a fixed idle gap between the STOP and the next START, up to
// RETRY_MAX extra attempts per entry.
//
// Ports
//   CLK        in   system clock, all logic on the rising edge
//   RST        in   asynchronous active-high reset
//   start      in   pulse, begins the sequence at entry 0 (ignored while busy)
//   busy       out  high from accepted start until done/error
//   done       out  one-cycle pulse, every entry written and ACKed
//   error      out  sticky failure flag, cleared by the next accepted start
//   err_index  out  index of the failing entry (valid while error)
//   tbl_addr   out  table read address
//   tbl_data   in   {dev[6:0], last, reg[7:0], data[7:0]}, 1-cycle latency
//   cmd_valid  out  command valid towards the byte engine
//   cmd_ready  in   byte engine accepts on cmd_valid & cmd_ready
//   cmd_op     out  0 START+WRITE, 1 WRITE, 2 WRITE+STOP, 3 STOP only
//   cmd_byte   out  byte to write (zero for STOP only)
//   rsp_valid  in   one-cycle pulse, outstanding command completed
//   rsp_nack   in   with rsp_valid, slave NACKed
// ---------------------------------------------------------------------------
module fmc_i2c_init_sequencer #(
  parameter int NUM_ENTRIES = 16,
  parameter int RETRY_MAX   = 3,
  parameter int RETRY_GAP   = 100,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [23:0]      tbl_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [7:0]       cmd_byte,
  input  logic             rsp_valid,
  input  logic             rsp_nack
);

  localparam int RTY_W = $clog2(RETRY_MAX + 1);
  localparam int GAP_W = $clog2(RETRY_GAP + 1);

  localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(RETRY_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(RETRY_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  localparam logic [1:0] OP_START_WR = 2'd0;
  localparam logic [1:0] OP_WR       = 2'd1;
  localparam logic [1:0] OP_WR_STOP  = 2'd2;
  localparam logic [1:0] OP_STOP     = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_LATCH     = 4'd2,
    S_SEND_ADDR = 4'd3,
    S_W_ADDR    = 4'd4,
    S_SEND_REG  = 4'd5,
    S_W_REG     = 4'd6,
    S_SEND_DATA = 4'd7,
    S_W_DATA    = 4'd8,
    S_NEXT      = 4'd9,
    S_SEND_STOP = 4'd10,
    S_W_STOP    = 4'd11,
    S_GAP       = 4'd12,
    S_DONE      = 4'd13,
    S_ERROR     = 4'd14
  } state_t;

  state_t             state,     state_nxt;
  logic [IDX_W-1:0]   index,     index_nxt;
  logic [RTY_W-1:0]   retry,     retry_nxt;
  logic [GAP_W-1:0]   gap_cnt,   gap_cnt_nxt;
  logic [23:0]        entry,     entry_nxt;
  logic               busy_nxt,  done_nxt,  error_nxt;
  logic [IDX_W-1:0]   err_index_nxt, tbl_addr_nxt;
  logic               cmd_valid_nxt;
  logic [1:0]         cmd_op_nxt;
  logic [7:0]         cmd_byte_nxt;

  // State and registered outputs; async reset drops cmd_valid at once and
  // no STOP is issued because the byte engine is reset alongside.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      index     <= '0;
      retry     <= '0;
      gap_cnt   <= '0;
      entry     <= 24'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      tbl_addr  <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= 2'd0;
      cmd_byte  <= 8'd0;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      retry     <= retry_nxt;
      gap_cnt   <= gap_cnt_nxt;
      entry     <= entry_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
      err_index <= err_index_nxt;
      tbl_addr  <= tbl_addr_nxt;
      cmd_valid <= cmd_valid_nxt;
      cmd_op    <= cmd_op_nxt;
      cmd_byte  <= cmd_byte_nxt;
    end
  end

  // Next-state and next-output decode; command fields are loaded on the
  // transition into each SEND state so they are stable while cmd_valid waits.
  always_comb begin
    state_nxt     = state;
    index_nxt     = index;
    retry_nxt     = retry;
    gap_cnt_nxt   = gap_cnt;
    entry_nxt     = entry;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    error_nxt     = error;
    err_index_nxt = err_index;
    tbl_addr_nxt  = tbl_addr;
    cmd_valid_nxt = cmd_valid;
    cmd_op_nxt    = cmd_op;
    cmd_byte_nxt  = cmd_byte;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_FETCH;
          index_nxt    = '0;
          retry_nxt    = '0;
          error_nxt    = 1'b0;
          busy_nxt     = 1'b1;
          tbl_addr_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      // tbl_addr is already presented; the ROM returns data next cycle.
      S_FETCH: begin
        state_nxt = S_LATCH;
      end

      S_LATCH: begin
        entry_nxt     = tbl_data;
        state_nxt     = S_SEND_ADDR;
        cmd_valid_nxt = 1'b1;
        cmd_op_nxt    = OP_START_WR;
        cmd_byte_nxt  = {tbl_data[23:17], 1'b0};
      end

      S_SEND_ADDR: begin
        if (cmd_ready) begin
          cmd_valid_nxt = 1'b0;
          state_nxt     = S_W_ADDR;
        end else begin
          state_nxt = S_SEND_ADDR;
        end
      end

      S_SEND_REG: begin
        if (cmd_ready) begin
          cmd_valid_nxt = 1'b0;
          state_nxt     = S_W_REG;
        end else begin
          state_nxt = S_SEND_REG;
        end
      end

      S_SEND_DATA: begin
        if (cmd_ready) begin
          cmd_valid_nxt = 1'b0;
          state_nxt     = S_W_DATA;
        end else begin
          state_nxt = S_SEND_DATA;
        end
      end

      S_SEND_STOP: begin
        if (cmd_ready) begin
          cmd_valid_nxt = 1'b0;
          state_nxt     = S_W_STOP;
        end else begin
          state_nxt = S_SEND_STOP;
        end
      end

      S_W_ADDR: begin
        if (rsp_valid && rsp_nack) begin
          state_nxt     = S_SEND_STOP;
          cmd_valid_nxt = 1'b1;
          cmd_op_nxt    = OP_STOP;
          cmd_byte_nxt  = 8'd0;
        end else if (rsp_valid) begin
          state_nxt     = S_SEND_REG;
          cmd_valid_nxt = 1'b1;
          cmd_op_nxt    = OP_WR;
          cmd_byte_nxt  = entry[15:8];
        end else begin
          state_nxt = S_W_ADDR;
        end
      end

      S_W_REG: begin
        if (rsp_valid && rsp_nack) begin
          state_nxt     = S_SEND_STOP;
          cmd_valid_nxt = 1'b1;
          cmd_op_nxt    = OP_STOP;
          cmd_byte_nxt  = 8'd0;
        end else if (rsp_valid) begin
          state_nxt     = S_SEND_DATA;
          cmd_valid_nxt = 1'b1;
          cmd_op_nxt    = OP_WR_STOP;
          cmd_byte_nxt  = entry[7:0];
        end else begin
          state_nxt = S_W_REG;
        end
      end

      // The data command carries its own STOP, so a NACK goes straight to GAP.
      S_W_DATA: begin
        if (rsp_valid && rsp_nack) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = '0;
        end else if (rsp_valid) begin
          state_nxt = S_NEXT;
        end else begin
          state_nxt = S_W_DATA;
        end
      end

      S_W_STOP: begin
        if (rsp_valid) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = '0;
        end else begin
          state_nxt = S_W_STOP;
        end
      end

      // Idle RETRY_GAP cycles, then resend the latched entry without refetch.
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (retry < RETRY_LIM) begin
            retry_nxt     = retry + RTY_W'(1);
            state_nxt     = S_SEND_ADDR;
            cmd_valid_nxt = 1'b1;
            cmd_op_nxt    = OP_START_WR;
            cmd_byte_nxt  = {entry[23:17], 1'b0};
          end else begin
            state_nxt     = S_ERROR;
            error_nxt     = 1'b1;
            err_index_nxt = index;
            busy_nxt      = 1'b0;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      // The last table slot is terminal even without its last flag.
      S_NEXT: begin
        retry_nxt = '0;
        if (entry[16] || (index == IDX_LAST)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          index_nxt    = index + IDX_ONE;
          tbl_addr_nxt = index + IDX_ONE;
          state_nxt    = S_FETCH;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      S_ERROR: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt     = S_IDLE;
        busy_nxt      = 1'b0;
        cmd_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fmc_i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fmc_i2c_init_sequencer
//
// Scoreboard bench. Each scenario loads a table and a NACK plan, a reference
// model expands them into the expected command list (with the response the
// byte-engine model must return), and an engine/monitor process pops and
// compares every accepted command while also checking handshake stability,
// single-outstanding behaviour and the retry gap length.
// ---------------------------------------------------------------------------
module tb_fmc_i2c_init_sequencer;

  localparam int N    = 16;
  localparam int RMAX = 3;
  localparam int GAP  = 100;
  localparam int IW   = 4;

  typedef struct {
    logic [1:0] op;
    logic [7:0] b;
    logic       nack;
    logic       retry;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [IW-1:0] err_index, tbl_addr;
  logic [23:0]   tbl_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_byte;
  logic          rsp_valid = 1'b0;
  logic          rsp_nack = 1'b0;

  logic [23:0] rom [N];
  bit          plan [N][3][RMAX+1];
  exp_t        exp_q [$];
  bit          exp_done, exp_err;
  int          exp_eidx;
  int          checks = 0;
  int          failures = 0;
  int          min_dly = 0;
  bit          stall5 = 1'b0;
  int          op1_count = 0;

  fmc_i2c_init_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_byte(cmd_byte), .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack)
  );

  always #5 CLK = ~CLK;

  // Table ROM with one cycle of read latency.
  always @(posedge CLK) tbl_data <= rom[tbl_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input logic [1:0] op, input logic [7:0] b,
                               input logic nack, input logic retry);
    exp_t e;
    e.op = op; e.b = b; e.nack = nack; e.retry = retry;
    exp_q.push_back(e);
  endfunction

  // Reference model: expand the table and NACK plan into the command list.
  function automatic void build_model();
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_eidx = 0;
    for (int i = 0; i < N; i++) begin
      bit ok;
      ok = 1'b0;
      for (int a = 0; a <= RMAX && !ok; a++) begin
        push(2'd0, {rom[i][23:17], 1'b0}, plan[i][0][a], a > 0);
        if (plan[i][0][a]) begin
          push(2'd3, 8'd0, 1'($urandom_range(0, 1)), 1'b0);
          continue;
        end
        push(2'd1, rom[i][15:8], plan[i][1][a], 1'b0);
        if (plan[i][1][a]) begin
          push(2'd3, 8'd0, 1'($urandom_range(0, 1)), 1'b0);
          continue;
        end
        push(2'd2, rom[i][7:0], plan[i][2][a], 1'b0);
        if (!plan[i][2][a]) ok = 1'b1;
      end
      if (!ok) begin
        exp_err = 1'b1; exp_eidx = i;
        return;
      end
      if (rom[i][16] || i == N - 1) begin
        exp_done = 1'b1;
        return;
      end
    end
  endfunction

  function automatic void clear_plan();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 3; p++)
        for (int a = 0; a <= RMAX; a++)
          plan[i][p][a] = 1'b0;
  endfunction

  function automatic void random_table(input int last_pos);
    for (int i = 0; i < N; i++) begin
      rom[i] = 24'($urandom);
      rom[i][16] = (i == last_pos);
    end
  endfunction

  // Byte-engine model and monitor: drives cmd_ready/rsp, pops the scoreboard.
  initial begin
    bit         pend, prev_stall, prev_valid;
    int         pend_cnt, cyc, last_rsp_cyc, rise_cyc, idle, hold, stall_cnt;
    logic       pend_nack;
    logic [1:0] prev_op;
    logic [7:0] prev_byte;
    exp_t       e;
    pend = 0; prev_stall = 0; prev_valid = 0; pend_cnt = 0; cyc = 0;
    last_rsp_cyc = 0; rise_cyc = 0; hold = 0; stall_cnt = 0; pend_nack = 0;
    prev_op = 2'd0; prev_byte = 8'd0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        pend = 0; prev_stall = 0; prev_valid = 0; stall_cnt = 0;
        rsp_valid = 1'b0; rsp_nack = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checks++;
        if (!cmd_valid || cmd_op !== prev_op || cmd_byte !== prev_byte) begin
          failures++;
          $display("FAIL stall_hold actual=%b/%0d/%h required=1/%0d/%h",
                   cmd_valid, cmd_op, cmd_byte, prev_op, prev_byte);
        end
      end
      if (cmd_valid && !prev_valid) rise_cyc = cyc;
      if (pend && cmd_valid) begin
        checks++; failures++;
        $display("FAIL one_outstanding actual=cmd_valid required=idle op=%0d", cmd_op);
      end
      rsp_valid = 1'b0; rsp_nack = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1; rsp_nack = pend_nack; pend = 0; last_rsp_cyc = cyc;
        end else begin
          pend_cnt--;
        end
      end
      if (stall5 && cmd_valid && cmd_op == 2'd1 && stall_cnt < 5) begin
        cmd_ready = 1'b0; stall_cnt++;
      end else if (hold > 0) begin
        cmd_ready = 1'b0; hold--;
      end else if ($urandom_range(0, 9) < 7) begin
        cmd_ready = 1'b1;
      end else begin
        cmd_ready = 1'b0; hold = $urandom_range(0, 4);
      end
      if (cmd_valid && cmd_ready) begin
        stall_cnt = 0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmd actual=op%0d/%h required=none", cmd_op, cmd_byte);
          pend_nack = 1'b0;
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (cmd_op !== e.op || (e.op != 2'd3 && cmd_byte !== e.b)) begin
            failures++;
            $display("FAIL cmd actual=op%0d/%h required=op%0d/%h", cmd_op, cmd_byte, e.op, e.b);
          end
          if (e.retry) begin
            idle = rise_cyc - last_rsp_cyc - 1;
            checks++;
            if (idle < GAP || idle > GAP + 2) begin
              failures++;
              $display("FAIL retry_gap actual=%0d required=%0d..%0d", idle, GAP, GAP + 2);
            end
          end
          pend_nack = e.nack;
        end
        if (cmd_op == 2'd1) op1_count++;
        pend = 1; pend_cnt = $urandom_range(min_dly, min_dly + 3);
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_valid = cmd_valid;
      prev_op = cmd_op; prev_byte = cmd_byte;
    end
  end

  task automatic run(input string name, input bit mid_start);
    bit fin;
    int drops;
    build_model();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    check({name, "_busy_on_start"}, 32'(busy), 32'd1);
    check({name, "_error_cleared"}, 32'(error), 32'd0);
    fin = 1'b0; drops = 0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      if (done || error) begin
        fin = 1'b1;
      end else begin
        if (!busy) drops++;
        @(negedge CLK);
        start = (mid_start && c == 40);
      end
    end
    start = 1'b0;
    check({name, "_finished"}, 32'(fin), 32'd1);
    check({name, "_busy_held"}, 32'(drops), 32'd0);
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    if (exp_err) check({name, "_err_index"}, 32'(err_index), 32'(exp_eidx));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_error_sticky"}, 32'(error), 32'(exp_err));
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({busy, done, error, cmd_valid, err_index, tbl_addr, cmd_op, cmd_byte}), 32'd0);
  endtask

  initial begin
    int base;
    bit seen;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_values");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Three entries, last flag on entry 2, all ACK, forced 5-cycle REG stall.
    clear_plan(); random_table(2); stall5 = 1'b1;
    run("three_entry", 1'b0);
    stall5 = 1'b0;

    // Entry 1 address NACKed once.
    clear_plan(); random_table(3); plan[1][0][0] = 1'b1;
    run("addr_nack_once", 1'b0);

    // Entry 0 data always NACKed: retries exhausted.
    clear_plan(); random_table(2);
    for (int a = 0; a <= RMAX; a++) plan[0][2][a] = 1'b1;
    run("data_nack_all", 1'b0);

    // Sixteen entries, none flagged; start pulsed mid-run.
    clear_plan(); random_table(-1);
    run("full_table", 1'b1);

    // Reset while waiting for the register-byte response.
    clear_plan(); random_table(2); build_model(); min_dly = 4;
    base = op1_count;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge CLK);
      seen = (op1_count != base);
    end
    check("rst_reached_w_reg", 32'(seen), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_immediate");
    @(negedge CLK);
    check_reset_outputs("rst_next_cycle");
    exp_q.delete();
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0; min_dly = 0;
    repeat (2) @(negedge CLK);
    run("after_reset", 1'b0);

    // Randomised tables and NACK plans.
    for (int s = 0; s < 6; s++) begin
      clear_plan();
      random_table($urandom_range(0, 19));
      for (int i = 0; i < N; i++)
        for (int p = 0; p < 3; p++)
          for (int a = 0; a <= RMAX; a++)
            plan[i][p][a] = ($urandom_range(0, 99) < 8);
      run($sformatf("random%0d", s), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
